led_seq_ctrl: RTL and testbench

Sequencer that drives the 5-bit LED up/down counter through a programmed list of up to 4 count segments (start value -> end value).
- Per segment: loads the counter, paces its steps with a clock-divided tick, waits for the end flag, holds a dwell, then advances to the next segment.
- Optionally loops the list.
- Sits between the board control logic (buttons/config registers) and the counter datapath.

---
 rtl/led_seq_ctrl_if.sv | 20 ++
 rtl/led_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_seq_ctrl_if.sv
// Counter-side bus between the sequencer (master) and the LED up/down counter datapath (slave).
interface led_seq_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic [WIDTH-1:0] cnt_end;
    logic             cnt_up;
    logic             cnt_step;
    logic             cnt_done;

    modport master (
        output cnt_load, cnt_load_val, cnt_end, cnt_up, cnt_step,
        input  cnt_done
    );
    modport slave (
        input  cnt_load, cnt_load_val, cnt_end, cnt_up, cnt_step,
        output cnt_done
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Segment sequencer for the LED up/down counter: walks a 4-entry {start,end} table,
// pacing counter steps with a divided tick and holding a dwell between segments.
module led_seq_ctrl #(
    parameter int WIDTH       = 5,
    parameter int TICK_DIV    = 4,
    parameter int DWELL_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [1:0]       last_seg,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_start,
    input  logic [WIDTH-1:0] wr_end,
    led_seq_ctrl_if.master   cnt,
    output logic [1:0]       seg_idx,
    output logic             busy,
    output logic             seq_done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DWELL
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [1:0]       seg_idx_q, seg_idx_d;
    logic [1:0]       last_seg_q, last_seg_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             up_q, up_d;
    logic             seq_done_q, seq_done_d;
    logic [WIDTH-1:0] tbl_start_q [4];
    logic [WIDTH-1:0] tbl_end_q   [4];

    logic             tick;
    logic             tbl_we;
    logic [WIDTH-1:0] nxt_start;
    logic [WIDTH-1:0] nxt_end;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        tick       = (presc_q == PRESC_LAST);
        tbl_we     = wr_en && (state_q == S_IDLE);
        state_d    = state_q;
        presc_d    = presc_q;
        dwell_d    = dwell_q;
        seg_idx_d  = seg_idx_q;
        last_seg_d = last_seg_q;
        load_d     = 1'b0;
        seq_done_d = 1'b0;
        load_val_d = load_val_q;
        end_d      = end_q;
        up_d       = up_q;
        nxt_start  = '0;
        nxt_end    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    seg_idx_d  = 2'd0;
                    last_seg_d = last_seg;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
                presc_d = '0;
            end
            S_RUN: begin
                if (cnt.cnt_done) begin
                    state_d = S_DWELL;
                    presc_d = '0;
                    dwell_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                end
            end
            S_DWELL: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (dwell_q == DWELL_LAST) begin
                        if (seg_idx_q < last_seg_q) begin
                            seg_idx_d = seg_idx_q + 1'b1;
                            state_d   = S_LOAD;
                        end else if (loop_en) begin
                            seg_idx_d = 2'd0;
                            state_d   = S_LOAD;
                        end else begin
                            state_d    = S_IDLE;
                            seq_done_d = 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition above, including a same-cycle start.
        if (stop) begin
            state_d    = S_IDLE;
            seq_done_d = 1'b0;
            seg_idx_d  = seg_idx_q;
            last_seg_d = last_seg_q;
        end

        // Load values are registered on entry to LOAD; a same-cycle idle write bypasses the table.
        if (state_d == S_LOAD) begin
            load_d    = 1'b1;
            nxt_start = tbl_start_q[seg_idx_d];
            nxt_end   = tbl_end_q[seg_idx_d];
            if (tbl_we && (wr_addr == seg_idx_d)) begin
                nxt_start = wr_start;
                nxt_end   = wr_end;
            end
            load_val_d = nxt_start;
            end_d      = nxt_end;
            up_d       = (nxt_end >= nxt_start);
        end
    end

    // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            dwell_q    <= '0;
            seg_idx_q  <= 2'd0;
            last_seg_q <= 2'd0;
            load_q     <= 1'b0;
            load_val_q <= '0;
            end_q      <= '0;
            up_q       <= 1'b0;
            seq_done_q <= 1'b0;
            // NOTE: the table is reset like any other flop; a cleared table is visible behaviour.
            for (int i = 0; i < 4; i++) begin
                tbl_start_q[i] <= '0;
                tbl_end_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            dwell_q    <= dwell_d;
            seg_idx_q  <= seg_idx_d;
            last_seg_q <= last_seg_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            end_q      <= end_d;
            up_q       <= up_d;
            seq_done_q <= seq_done_d;
            if (tbl_we) begin
                tbl_start_q[wr_addr] <= wr_start;
                tbl_end_q[wr_addr]   <= wr_end;
            end
        end
    end

    // Step is combinational on cnt_done so the counter never overshoots, even at TICK_DIV=1.
    assign cnt.cnt_step     = (state_q == S_RUN) && tick && !cnt.cnt_done && !stop;
    assign cnt.cnt_load     = load_q;
    assign cnt.cnt_load_val = load_val_q;
    assign cnt.cnt_end      = end_q;
    assign cnt.cnt_up       = up_q;
    assign seg_idx          = seg_idx_q;
    assign busy             = (state_q != S_IDLE);
    assign seq_done         = seq_done_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus pushes expected load/done events, monitors
// pop and compare them against a behavioural counter model driven by the sequencer.
module tb_led_seq_ctrl;
    localparam int W  = 5;
    localparam int TD = 4;
    localparam int DT = 2;

    typedef enum int {EV_LOAD = 0, EV_DONE = 1} ev_kind_e;
    typedef struct {
        ev_kind_e     kind;
        logic [W-1:0] val;
        logic [W-1:0] end_v;
        logic         up;
        logic [1:0]   seg;
        int           steps;
        bit           from_start;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1, stop, loop_en, wr_en;
    logic [1:0]   last_seg, wr_addr;
    logic [W-1:0] wr_start, wr_end;
    logic [1:0]   seg_idx0, seg_idx1;
    logic         busy0, busy1, seq_done0, seq_done1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    led_seq_ctrl_if #(.WIDTH(W)) cnt_if0 ();
    led_seq_ctrl_if #(.WIDTH(W)) cnt_if1 ();

    led_seq_ctrl #(.WIDTH(W), .TICK_DIV(TD), .DWELL_TICKS(DT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .last_seg(last_seg), .wr_en(wr_en), .wr_addr(wr_addr), .wr_start(wr_start),
        .wr_end(wr_end), .cnt(cnt_if0), .seg_idx(seg_idx0), .busy(busy0), .seq_done(seq_done0)
    );

    led_seq_ctrl #(.WIDTH(W), .TICK_DIV(1), .DWELL_TICKS(DT)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .loop_en(loop_en),
        .last_seg(last_seg), .wr_en(wr_en), .wr_addr(wr_addr), .wr_start(wr_start),
        .wr_end(wr_end), .cnt(cnt_if1), .seg_idx(seg_idx1), .busy(busy1), .seq_done(seq_done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural LED counters driven by each sequencer.
    logic [W-1:0] cval0, cval1;
    always_ff @(posedge clk) begin
        if (rst) begin
            cval0 <= '0;
            cval1 <= '0;
        end else begin
            if (cnt_if0.cnt_load)      cval0 <= cnt_if0.cnt_load_val;
            else if (cnt_if0.cnt_step) cval0 <= cnt_if0.cnt_up ? cval0 + 1'b1 : cval0 - 1'b1;
            if (cnt_if1.cnt_load)      cval1 <= cnt_if1.cnt_load_val;
            else if (cnt_if1.cnt_step) cval1 <= cnt_if1.cnt_up ? cval1 + 1'b1 : cval1 - 1'b1;
        end
    end
    assign cnt_if0.cnt_done = (cval0 == cnt_if0.cnt_end);
    assign cnt_if1.cnt_done = (cval1 == cnt_if1.cnt_end);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t q0[$];
    int   q1[$];

    function automatic void push_load(input int val, input int end_v, input bit up,
                                      input int seg, input int steps, input bit fs);
        exp_t e;
        e.kind = EV_LOAD; e.val = W'(val); e.end_v = W'(end_v); e.up = up;
        e.seg = 2'(seg); e.steps = steps; e.from_start = fs;
        q0.push_back(e);
    endfunction

    function automatic void push_done(input int seg, input int steps);
        exp_t e;
        e.kind = EV_DONE; e.val = '0; e.end_v = '0; e.up = 1'b0;
        e.seg = 2'(seg); e.steps = steps; e.from_start = 1'b0;
        q0.push_back(e);
    endfunction

    // Monitor for the TICK_DIV=4 instance.
    int   step_cnt = 0, ref_cyc = 0, done_cyc = 0;
    bit   done_armed = 0, done_seen = 0;
    exp_t ev;
    always @(negedge clk) begin
        if (rst) begin
            step_cnt = 0; done_armed = 0; done_seen = 0;
        end else begin
            if (cnt_if0.cnt_step) begin
                check("step_gap", cyc - ref_cyc, TD);
                step_cnt++;
                ref_cyc = cyc;
            end
            if (done_armed && cnt_if0.cnt_done && !cnt_if0.cnt_load) begin
                done_cyc = cyc; done_armed = 0; done_seen = 1;
            end
            if (cnt_if0.cnt_load || seq_done0) begin
                if (q0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_event: load=%0d seq_done=%0d, expected none (cycle %0d)",
                             cnt_if0.cnt_load, seq_done0, cyc);
                end else begin
                    ev = q0.pop_front();
                    check("ev_kind", cnt_if0.cnt_load ? int'(EV_LOAD) : int'(EV_DONE), int'(ev.kind));
                    if (ev.from_start) begin
                        check("start_lat", cyc - start_cyc, 1);
                    end else begin
                        check("ev_steps", step_cnt, ev.steps);
                        check("done_seen", int'(done_seen), 1);
                        if (done_seen) check("dwell_lat", cyc - done_cyc, DT * TD + 1);
                    end
                    check("ev_seg", seg_idx0, ev.seg);
                    if (cnt_if0.cnt_load) begin
                        check("load_val", cnt_if0.cnt_load_val, ev.val);
                        check("load_end", cnt_if0.cnt_end, ev.end_v);
                        check("load_up", cnt_if0.cnt_up, ev.up);
                    end
                end
                step_cnt = 0; ref_cyc = cyc; done_seen = 0;
                done_armed = cnt_if0.cnt_load;
            end
        end
    end

    // Monitor for the TICK_DIV=1 instance: steps must come every cycle until cnt_done.
    int steps1 = 0, ref1 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (cnt_if1.cnt_step) begin
                check("step_gap1", cyc - ref1, 1);
                steps1++;
                ref1 = cyc;
            end
            if (cnt_if1.cnt_load) begin
                steps1 = 0; ref1 = cyc;
            end
            if (seq_done1) begin
                if (q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_done1: got seq_done, expected none (cycle %0d)", cyc);
                end else begin
                    check("steps1", steps1, q1.pop_front());
                end
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q0(input int n_left, input int budget);
        int i = 0;
        while (q0.size() > n_left && i < budget) begin step_cycle(); i++; end
        check("q0_drain", q0.size(), n_left);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((busy0 || busy1) && i < budget) begin step_cycle(); i++; end
        check("idle_timeout", int'(busy0 | busy1), 0);
    endtask

    task automatic write_tbl(input int addr, input int s, input int e);
        wr_en = 1'b1; wr_addr = 2'(addr); wr_start = W'(s); wr_end = W'(e);
        step_cycle();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; start_cyc = cyc;
        step_cycle();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_seg"}, seg_idx0, 0);
        check({tag, "_done"}, seq_done0, 0);
        check({tag, "_load"}, cnt_if0.cnt_load, 0);
        check({tag, "_step"}, cnt_if0.cnt_step, 0);
        check({tag, "_lval"}, cnt_if0.cnt_load_val, 0);
        check({tag, "_end"}, cnt_if0.cnt_end, 0);
        check({tag, "_up"}, cnt_if0.cnt_up, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst = 1'b1; start = 0; start1 = 0; stop = 0; loop_en = 0; last_seg = 0;
        wr_en = 0; wr_addr = 0; wr_start = 0; wr_end = 0;
        repeat (3) step_cycle();
        rst = 1'b0;
        check_reset_outputs("rst");

        // Single up segment 3 -> 6: three steps, then seq_done where the next load would fall.
        write_tbl(0, 3, 6);
        push_load(3, 6, 1, 0, 0, 1);
        push_done(0, 3);
        pulse_start();
        wait_q0(0, 100);
        wait_idle(20);

        // Stop after one step; a write attempted while busy must be dropped.
        push_load(3, 6, 1, 0, 0, 1);
        pulse_start();
        wait_q0(0, 10);
        write_tbl(0, 0, 31);
        i = 0;
        while (step_cnt < 1 && i < 20) begin step_cycle(); i++; end
        check("pre_stop_steps", step_cnt, 1);
        stop = 1'b1;
        step_cycle();
        stop = 1'b0;
        check("stop_busy", busy0, 0);
        repeat (20) step_cycle();
        check("stop_steps", step_cnt, 1);
        check("stop_seg", seg_idx0, 0);

        // Rerun reloads the unchanged start value.
        push_load(3, 6, 1, 0, 0, 1);
        push_done(0, 3);
        pulse_start();
        wait_q0(0, 100);
        wait_idle(20);

        // Write in the same cycle as start is used by the load; 0 -> 31 is 31 steps up.
        push_load(0, 31, 1, 0, 0, 1);
        push_done(0, 31);
        wr_en = 1'b1; wr_addr = 2'd0; wr_start = 5'd0; wr_end = 5'd31;
        pulse_start();
        wr_en = 1'b0;
        wait_q0(0, 400);
        wait_idle(20);

        // 31 -> 0 counts down 31 steps.
        write_tbl(0, 31, 0);
        push_load(31, 0, 0, 0, 0, 1);
        push_done(0, 31);
        pulse_start();
        wait_q0(0, 400);
        wait_idle(20);

        // start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        step_cycle();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy0, 0);
        repeat (10) step_cycle();
        check("ss_busy_later", busy0, 0);

        // TICK_DIV=1 instance: 4 -> 9 steps on five consecutive cycles.
        write_tbl(0, 4, 9);
        q1.push_back(5);
        start1 = 1'b1;
        step_cycle();
        start1 = 1'b0;
        i = 0;
        while (q1.size() > 0 && i < 50) begin step_cycle(); i++; end
        check("q1_drain", q1.size(), 0);
        wait_idle(20);

        // Two segments with loop: 10 -> 7 down, 2 -> 2 dwell only, then back to segment 0.
        write_tbl(0, 10, 7);
        write_tbl(1, 2, 2);
        last_seg = 2'd1; loop_en = 1'b1;
        push_load(10, 7, 0, 0, 0, 1);
        push_load(2, 2, 1, 1, 3, 0);
        push_load(10, 7, 0, 0, 0, 0);
        pulse_start();
        wait_q0(1, 100);
        start = 1'b1;
        step_cycle();
        start = 1'b0;
        wait_q0(0, 100);
        check("loop_busy", busy0, 1);
        check("loop_seg", seg_idx0, 0);
        stop = 1'b1;
        step_cycle();
        stop = 1'b0;
        check("loop_stop_busy", busy0, 0);
        last_seg = 2'd0; loop_en = 1'b0;
        repeat (5) step_cycle();

        // Reset during DWELL clears outputs and the table.
        write_tbl(0, 5, 6);
        push_load(5, 6, 1, 0, 0, 1);
        pulse_start();
        wait_q0(0, 10);
        i = 0;
        while (!(cnt_if0.cnt_done && !cnt_if0.cnt_load) && i < 20) begin step_cycle(); i++; end
        check("pre_rst_done", cnt_if0.cnt_done, 1);
        repeat (2) step_cycle();
        check("pre_rst_busy", busy0, 1);
        rst = 1'b1;
        step_cycle();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        step_cycle();
        push_load(0, 0, 1, 0, 0, 1);
        push_done(0, 0);
        pulse_start();
        wait_q0(0, 50);
        wait_idle(20);

        repeat (5) step_cycle();
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
